// File: rtl/hybd_seq_pkg.sv
// Shared encodings for the hybrid-top ingest sequencer: FSM states and hybd_status bit positions.
package hybd_seq_pkg;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_CFG    = 3'd1,
        S_WAIT   = 3'd2,
        S_STREAM = 3'd3,
        S_DRAIN  = 3'd4
    } seq_state_e;

    localparam int unsigned ST_SYNC_DONE = 0;
    localparam int unsigned ST_FIFO_REN  = 1;
    localparam int unsigned ST_RPK       = 2;
    localparam int unsigned ST_DONE      = 3;

endpackage

// File: rtl/hybd_seq_credit.sv
// Saturating FIFO credit counter: load to the limit, decrement per written sample, add a window
// per consumed block, and flag any return that would overshoot the limit.
module hybd_seq_credit #(
    parameter int unsigned CNT_W      = 12,
    parameter int unsigned FIFO_LIMIT = 2048,
    parameter int unsigned WIN_CREDIT = 800
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             inc,
    input  logic             dec,
    output logic [CNT_W-1:0] credit,
    output logic [CNT_W-1:0] credit_next,
    output logic             sat_err
);

    localparam logic [CNT_W:0] LIMIT = (CNT_W + 1)'(FIFO_LIMIT);
    localparam logic [CNT_W:0] WIN   = (CNT_W + 1)'(WIN_CREDIT);

    logic [CNT_W:0] sum;

    // Add before subtracting so a simultaneous return and write never wraps below zero.
    always_comb begin
        sum     = {1'b0, credit};
        sat_err = 1'b0;
        if (inc) begin
            sum = sum + WIN;
        end
        if (dec) begin
            sum = sum - (CNT_W + 1)'(1);
        end
        if (load) begin
            credit_next = LIMIT[CNT_W-1:0];
        end else if (sum > LIMIT) begin
            credit_next = LIMIT[CNT_W-1:0];
            sat_err     = 1'b1;
        end else begin
            credit_next = sum[CNT_W-1:0];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            credit <= LIMIT[CNT_W-1:0];
        end else begin
            credit <= credit_next;
        end
    end

endmodule

// File: rtl/hybd_ingest_seq.sv
// Ingest sequencer: routes SYNC_LIMIT samples to sync config, then credit-throttled samples to
// the FIFO. Define SEQ_TIMEOUT_EN to add a WAIT_SYNC watchdog of TMO_CYC cycles.
module hybd_ingest_seq
    import hybd_seq_pkg::*;
#(
    parameter int unsigned DATA_W     = 16,
    parameter int unsigned SYNC_LIMIT = 800,
    parameter int unsigned FIFO_LIMIT = 2048,
    parameter int unsigned WIN_CREDIT = 800,
    parameter int unsigned CNT_W      = 12,
    parameter int unsigned TMO_CYC    = 65535
) (
    input  logic              core_clk,
    input  logic              reset,
    input  logic              start,
    input  logic              stop,
    input  logic              smp_valid,
    input  logic [DATA_W-1:0] smp_data,
    output logic              smp_ready,
    input  logic [3:0]        hybd_status,
    output logic              sync_mux_en,
    output logic [DATA_W-1:0] sync_data,
    output logic              fifo_mux_en,
    output logic [DATA_W-1:0] fifo_data,
    output logic              test_ctrl_en,
    output logic [2:0]        seq_state,
    output logic              seq_err
);

    seq_state_e       state_q, state_d;
    logic [CNT_W-1:0] cfg_cnt_q, cfg_cnt_d;
    logic [CNT_W-1:0] credit, credit_next;
    logic             done_q, done_rise;
    logic             accept, cr_load, cr_inc, cr_dec, cr_sat;
    logic             tmo_hit, tmo_err;
    logic             smp_ready_d, test_ctrl_en_d, seq_err_d;
    logic             unused_status;

    assign accept        = smp_valid & smp_ready;
    assign done_rise     = hybd_status[ST_DONE] & ~done_q;
    assign unused_status = ^{hybd_status[ST_FIFO_REN], hybd_status[ST_RPK]};

`ifdef SEQ_TIMEOUT_EN
    localparam int unsigned TMO_W = $clog2(TMO_CYC + 1);
    logic [TMO_W-1:0] tmo_cnt_q;

    always_ff @(posedge core_clk or posedge reset) begin
        if (reset) begin
            tmo_cnt_q <= '0;
        end else if (state_q == S_WAIT) begin
            tmo_cnt_q <= tmo_cnt_q + TMO_W'(1);
        end else begin
            tmo_cnt_q <= '0;
        end
    end

    assign tmo_hit = (state_q == S_WAIT) && (tmo_cnt_q == TMO_W'(TMO_CYC - 1));
`else
    logic [31:0] unused_tmo;
    assign unused_tmo = TMO_CYC;
    assign tmo_hit    = 1'b0;
`endif

    always_comb begin
        state_d   = state_q;
        cfg_cnt_d = cfg_cnt_q;
        cr_load   = 1'b0;
        tmo_err   = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d   = S_CFG;
                    cfg_cnt_d = '0;
                    cr_load   = 1'b1;
                end
            end
            S_CFG: begin
                if (accept) begin
                    cfg_cnt_d = cfg_cnt_q + CNT_W'(1);
                end
                if (stop) begin
                    state_d = S_IDLE;
                end else if (accept && (cfg_cnt_q == CNT_W'(SYNC_LIMIT - 1))) begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (stop) begin
                    state_d = S_IDLE;
                end else if (hybd_status[ST_SYNC_DONE]) begin
                    state_d = S_STREAM;
                end else if (tmo_hit) begin
                    state_d = S_IDLE;
                    tmo_err = 1'b1;
                end
            end
            S_STREAM: begin
                if (stop) begin
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (stop || (credit == CNT_W'(FIFO_LIMIT))) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Credit only moves while the FIFO path is live; outside it the counter sits at the limit.
    assign cr_dec = accept && (state_q == S_STREAM);
    assign cr_inc = done_rise && ((state_q == S_STREAM) || (state_q == S_DRAIN));

    hybd_seq_credit #(
        .CNT_W      (CNT_W),
        .FIFO_LIMIT (FIFO_LIMIT),
        .WIN_CREDIT (WIN_CREDIT)
    ) u_credit (
        .clk         (core_clk),
        .rst         (reset),
        .load        (cr_load),
        .inc         (cr_inc),
        .dec         (cr_dec),
        .credit      (credit),
        .credit_next (credit_next),
        .sat_err     (cr_sat)
    );

    // Registered handshake outputs are computed from next state so they align with state_q.
    always_comb begin
        smp_ready_d    = (state_d == S_CFG) ||
                         ((state_d == S_STREAM) && (credit_next != '0));
        test_ctrl_en_d = (state_d == S_STREAM) || (state_d == S_DRAIN);
        seq_err_d      = cr_load ? 1'b0 : (seq_err | cr_sat | tmo_err);
    end

    always_ff @(posedge core_clk or posedge reset) begin
        if (reset) begin
            state_q      <= S_IDLE;
            cfg_cnt_q    <= '0;
            done_q       <= 1'b0;
            smp_ready    <= 1'b0;
            test_ctrl_en <= 1'b0;
            seq_err      <= 1'b0;
            sync_mux_en  <= 1'b0;
            sync_data    <= '0;
            fifo_mux_en  <= 1'b0;
            fifo_data    <= '0;
        end else begin
            state_q      <= state_d;
            cfg_cnt_q    <= cfg_cnt_d;
            done_q       <= hybd_status[ST_DONE];
            smp_ready    <= smp_ready_d;
            test_ctrl_en <= test_ctrl_en_d;
            seq_err      <= seq_err_d;
            sync_mux_en  <= accept && (state_q == S_CFG);
            fifo_mux_en  <= accept && (state_q == S_STREAM);
            if (accept && (state_q == S_CFG)) begin
                sync_data <= smp_data;
            end
            if (accept && (state_q == S_STREAM)) begin
                fifo_data <= smp_data;
            end
        end
    end

    assign seq_state = state_q;

endmodule
